// File: rtl/vram_port_arbiter.sv
// Arbiter sharing exmem port 2 between the VGA pixel fetcher (fixed priority, read-only)
// and an IO/loader master, with a starvation counter guaranteeing IO forward progress.
module vram_port_arbiter #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned IO_MAX_WAIT = 8,
   parameter int unsigned CNT_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_rvalid,
   output logic [DATA_W-1:0] io_rdata,
   output logic [ADDR_W-1:0] mem_addr2,
   output logic [DATA_W-1:0] mem_din2,
   output logic              mem_we2,
   input  logic [DATA_W-1:0] mem_dout2,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   localparam logic [CNT_W-1:0] MaxWait = CNT_W'(IO_MAX_WAIT);

   state_e              state_q;
   logic                owner_io_q;
   logic                owner_we_q;
   logic [CNT_W-1:0]    starve_cnt_q;
   logic                vga_gnt_q;
   logic                io_gnt_q;
   logic                vga_rvalid_q;
   logic                io_rvalid_q;
   logic                mem_we2_q;
   logic [ADDR_W-1:0]   mem_addr2_q;
   logic [DATA_W-1:0]   mem_din2_q;
   logic                busy_q;
   logic                io_win;
   logic                vga_win;

   always_comb begin
      io_win  = io_req && (!vga_req || (starve_cnt_q == MaxWait));
      vga_win = vga_req && !io_win;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         owner_io_q   <= 1'b0;
         owner_we_q   <= 1'b0;
         starve_cnt_q <= '0;
         vga_gnt_q    <= 1'b0;
         io_gnt_q     <= 1'b0;
         vga_rvalid_q <= 1'b0;
         io_rvalid_q  <= 1'b0;
         mem_we2_q    <= 1'b0;
         mem_addr2_q  <= '0;
         mem_din2_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         // Grant, rvalid and write-enable are single-cycle pulses by default.
         vga_gnt_q    <= 1'b0;
         io_gnt_q     <= 1'b0;
         vga_rvalid_q <= 1'b0;
         io_rvalid_q  <= 1'b0;
         mem_we2_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (io_win || !io_req) begin
                  starve_cnt_q <= '0;
               end else if (starve_cnt_q != MaxWait) begin
                  starve_cnt_q <= starve_cnt_q + 1'b1;
               end
               if (io_win || vga_win) begin
                  owner_io_q  <= io_win;
                  owner_we_q  <= io_win && io_we;
                  mem_addr2_q <= io_win ? io_addr : vga_addr;
                  mem_din2_q  <= io_win ? io_wdata : '0;
                  mem_we2_q   <= io_win && io_we;
                  vga_gnt_q   <= vga_win;
                  io_gnt_q    <= io_win;
                  busy_q      <= 1'b1;
                  state_q     <= StAccess;
               end
            end
            StAccess: begin
               vga_rvalid_q <= !owner_io_q;
               io_rvalid_q  <= owner_io_q && !owner_we_q;
               state_q      <= StResp;
            end
            StResp: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign vga_gnt    = vga_gnt_q;
   assign io_gnt     = io_gnt_q;
   assign vga_rvalid = vga_rvalid_q;
   assign io_rvalid  = io_rvalid_q;
   assign vga_rdata  = mem_dout2;
   assign io_rdata   = mem_dout2;
   assign mem_addr2  = mem_addr2_q;
   assign mem_din2   = mem_din2_q;
   assign mem_we2    = mem_we2_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed cycle table, arbitration sequences
// and a randomised exclusivity run against a behavioural synchronous RAM.
module tb_vram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        vga_req;
   logic [15:0] vga_addr;
   logic        vga_gnt, vga_rvalid;
   logic [15:0] vga_rdata;
   logic        io_req, io_we;
   logic [15:0] io_addr, io_wdata;
   logic        io_gnt, io_rvalid;
   logic [15:0] io_rdata;
   logic [15:0] mem_addr2, mem_din2, mem_dout2;
   logic        mem_we2;
   logic        busy;

   logic [15:0] mem [0:65535];

   int checks   = 0;
   int failures = 0;

   vram_port_arbiter #(
      .ADDR_W     (16),
      .DATA_W     (16),
      .IO_MAX_WAIT(8),
      .CNT_W      (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .vga_req   (vga_req),
      .vga_addr  (vga_addr),
      .vga_gnt   (vga_gnt),
      .vga_rvalid(vga_rvalid),
      .vga_rdata (vga_rdata),
      .io_req    (io_req),
      .io_we     (io_we),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_gnt    (io_gnt),
      .io_rvalid (io_rvalid),
      .io_rdata  (io_rdata),
      .mem_addr2 (mem_addr2),
      .mem_din2  (mem_din2),
      .mem_we2   (mem_we2),
      .mem_dout2 (mem_dout2),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we2) mem[mem_addr2] <= mem_din2;
      mem_dout2 <= mem[mem_addr2];
   end

   typedef struct {
      logic        rst, vreq;
      logic [15:0] vaddr;
      logic        ireq, iwe;
      logic [15:0] iaddr, iwd;
      logic        e_vg, e_vr, e_ig, e_ir, e_we, e_busy;
      logic        chk_addr;
      logic [15:0] e_addr, e_din;
      logic        chk_rd;
      logic [15:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic vreq, input logic [15:0] vaddr,
                      input logic ireq, input logic iwe, input logic [15:0] iaddr,
                      input logic [15:0] iwd, input logic vg, input logic vr, input logic ig,
                      input logic ir, input logic we, input logic bsy, input logic ca,
                      input logic [15:0] ea, input logic [15:0] ed, input logic cr,
                      input logic [15:0] er);
      vec_t v;
      v.rst = rst; v.vreq = vreq; v.vaddr = vaddr; v.ireq = ireq; v.iwe = iwe;
      v.iaddr = iaddr; v.iwd = iwd; v.e_vg = vg; v.e_vr = vr; v.e_ig = ig; v.e_ir = ir;
      v.e_we = we; v.e_busy = bsy; v.chk_addr = ca; v.e_addr = ea; v.e_din = ed;
      v.chk_rd = cr; v.e_rd = er;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; vga_req = 1'b0; io_req = 1'b0; io_we = 1'b0;
      vga_addr = '0; io_addr = '0; io_wdata = '0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // Both requesters pending; io_req is withdrawn at the IDLE sample numbered drop.
   task automatic run_arb(input string nm, input int drop, input int n, input int e1,
                          input int e2);
      logic got [0:31];
      int   k = 0;
      do_reset();
      vga_req = 1'b1; vga_addr = 16'h0040; io_we = 1'b0; io_addr = 16'h0300;
      for (int cyc = 0; cyc < 300 && k < n; cyc++) begin
         io_req = (k != drop);
         @(posedge clk); #1;
         if (vga_gnt || io_gnt) begin
            got[k] = io_gnt;
            k++;
         end
      end
      chk($sformatf("%s_grants_seen", nm), k, n);
      for (int i = 0; i < k; i++)
         chk($sformatf("%s_grant%0d_is_io", nm, i), {31'd0, got[i]}, {31'd0, (i == e1 || i == e2)});
      vga_req = 1'b0; io_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      logic pv, pi, pwe;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0100] = 16'hBEEF;

      //   rst vreq vaddr    ireq iwe iaddr     iwd       vg vr ig ir we bsy ca addr      din       cr rd
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
      add(1, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1, 1, 16'h0100, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'hBEEF);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 0, 0, 1, 0, 1, 1, 1, 16'h0200, 16'h1234, 0, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 0, 1, 0, 0, 1, 1, 16'h0200, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'h1234);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 1, 1, 16'h0010, 16'hA5A5, 0, 0, 1, 0, 1, 1, 1, 16'h0010, 16'hA5A5, 0, 0);
      add(0, 0, 16'h0000, 1, 1, 16'h0010, 16'hA5A5, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
      add(1, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1, 1, 16'h0100, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'hBEEF);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);

      reset = 1'b0; vga_req = 1'b0; io_req = 1'b0; io_we = 1'b0;
      vga_addr = '0; io_addr = '0; io_wdata = '0;
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; vga_req = vecs[i].vreq; vga_addr = vecs[i].vaddr;
         io_req = vecs[i].ireq; io_we = vecs[i].iwe; io_addr = vecs[i].iaddr;
         io_wdata = vecs[i].iwd;
         @(posedge clk); #1;
         chk($sformatf("row%0d_vga_gnt", i), vga_gnt, vecs[i].e_vg);
         chk($sformatf("row%0d_vga_rvalid", i), vga_rvalid, vecs[i].e_vr);
         chk($sformatf("row%0d_io_gnt", i), io_gnt, vecs[i].e_ig);
         chk($sformatf("row%0d_io_rvalid", i), io_rvalid, vecs[i].e_ir);
         chk($sformatf("row%0d_mem_we2", i), mem_we2, vecs[i].e_we);
         chk($sformatf("row%0d_busy", i), busy, vecs[i].e_busy);
         if (vecs[i].chk_addr) begin
            chk($sformatf("row%0d_mem_addr2", i), mem_addr2, vecs[i].e_addr);
            chk($sformatf("row%0d_mem_din2", i), mem_din2, vecs[i].e_din);
         end
         if (vecs[i].chk_rd)
            chk($sformatf("row%0d_rdata", i), vecs[i].e_vr ? vga_rdata : io_rdata, vecs[i].e_rd);
      end
      chk("reset_mid_write_mem", mem[16'h0010], 16'hA5A5);

      run_arb("priority", -1, 18, 8, 17);
      run_arb("starve_clear", 5, 15, 14, -1);

      do_reset();
      pv = 1'b0; pi = 1'b0; pwe = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk); #1;
         chk("excl_gnt", {31'd0, vga_gnt & io_gnt}, 32'd0);
         chk("excl_rvalid", {31'd0, vga_rvalid & io_rvalid}, 32'd0);
         chk("rand_vga_rvalid", {31'd0, vga_rvalid}, {31'd0, pv});
         chk("rand_io_rvalid", {31'd0, io_rvalid}, {31'd0, pi & ~pwe});
         pv = vga_gnt; pi = io_gnt; pwe = mem_we2;
         if (vga_gnt) vga_req = 1'b0;
         else if (!vga_req && $urandom_range(3) == 0) begin
            vga_req = 1'b1; vga_addr = 16'($urandom_range(255));
         end
         if (io_gnt) io_req = 1'b0;
         else if (!io_req && $urandom_range(3) == 0) begin
            io_req = 1'b1; io_we = 1'($urandom_range(1));
            io_addr = 16'($urandom_range(255)); io_wdata = 16'($urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
